// File: rtl/mem_bus_pkg.sv
// Shared definitions for the MCU memory bus: default widths, arbiter states
// and the data word returned on an aborted access.
package mem_bus_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    // Read data handed back when an access is aborted; memory models reuse it.
    localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single memory port: round-robin or fixed
// priority selection, registered bus outputs and a per-access watchdog.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_en,
    input  logic          m0_we,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_en,
    input  logic          m1_we,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic [AW-1:0] s_addr,
    output logic          s_en,
    output logic          s_we,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic [1:0]    grant,
    output logic          timeout_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    arb_state_e    state_reg;
    logic          last_reg;
    logic [CW-1:0] cnt_reg;

    logic          any_req;
    logic          pick_m1;
    logic          abort_now;
    logic [DW-1:0] done_data;

    // Winner selection; on contention with round-robin the master that did
    // not own the bus last time goes first.
    always_comb begin
        any_req = m0_en | m1_en;
        pick_m1 = 1'b0;
        if (m1_en && !m0_en) begin
            pick_m1 = 1'b1;
        end else if (m0_en && m1_en && (ROUND_ROBIN != 0)) begin
            pick_m1 = ~last_reg;
        end
    end

    // A real acknowledge in the abort cycle takes precedence over the watchdog.
    always_comb begin
        abort_now = (TIMEOUT != 0) && (cnt_reg == CNT_LAST) && !s_ready;
        done_data = s_ready ? s_rdata : DW'(BUS_ERR_DATA);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            cnt_reg     <= '0;
            s_addr      <= '0;
            s_en        <= 1'b0;
            s_we        <= 1'b0;
            s_wdata     <= '0;
            m0_rdata    <= '0;
            m0_ready    <= 1'b0;
            m1_rdata    <= '0;
            m1_ready    <= 1'b0;
            grant       <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        s_addr    <= pick_m1 ? m1_addr  : m0_addr;
                        s_we      <= pick_m1 ? m1_we    : m0_we;
                        s_wdata   <= pick_m1 ? m1_wdata : m0_wdata;
                        s_en      <= 1'b1;
                        grant     <= pick_m1 ? 2'b10 : 2'b01;
                        cnt_reg   <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready || abort_now) begin
                        if (grant[1]) begin
                            m1_rdata <= done_data;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= done_data;
                            m0_ready <= 1'b1;
                        end
                        timeout_err <= abort_now;
                        s_en        <= 1'b0;
                        s_we        <= 1'b0;
                        last_reg    <= grant[1];
                        state_reg   <= RELEASE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RELEASE: begin
                    m0_ready    <= 1'b0;
                    m1_ready    <= 1'b0;
                    timeout_err <= 1'b0;
                    grant       <= 2'b00;
                    state_reg   <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance run side
// by side against a cycle-level reference model, directed cases then random.
module tb_mem_arbiter;
    import mem_bus_pkg::*;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Index [k] = instance (0: round-robin, 1: fixed priority), [m] = master.
    logic [15:0] m_addr  [2][2];
    logic        m_en    [2][2];
    logic        m_we    [2][2];
    logic [15:0] m_wdata [2][2];
    logic [15:0] m_rdata [2][2];
    logic        m_ready [2][2];
    logic [15:0] s_addr  [2];
    logic        s_en    [2];
    logic        s_we    [2];
    logic [15:0] s_wdata [2];
    logic [15:0] s_rdata [2];
    logic        s_ready [2];
    logic [1:0]  grant   [2];
    logic        terr    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_arbiter #(
            .AW(16), .DW(16), .ROUND_ROBIN((gi == 0) ? 1 : 0), .TIMEOUT(T)
        ) dut (
            .clk(clk), .reset(rst_n),
            .m0_addr(m_addr[gi][0]), .m0_en(m_en[gi][0]), .m0_we(m_we[gi][0]),
            .m0_wdata(m_wdata[gi][0]), .m0_rdata(m_rdata[gi][0]), .m0_ready(m_ready[gi][0]),
            .m1_addr(m_addr[gi][1]), .m1_en(m_en[gi][1]), .m1_we(m_we[gi][1]),
            .m1_wdata(m_wdata[gi][1]), .m1_rdata(m_rdata[gi][1]), .m1_ready(m_ready[gi][1]),
            .s_addr(s_addr[gi]), .s_en(s_en[gi]), .s_we(s_we[gi]), .s_wdata(s_wdata[gi]),
            .s_rdata(s_rdata[gi]), .s_ready(s_ready[gi]),
            .grant(grant[gi]), .timeout_err(terr[gi])
        );
    end

    int checks = 0;
    int failures = 0;
    int mcyc = 0;
    bit rand_on = 0;

    logic        rdy_prev [2][2];
    int          wait_c   [2][2];
    int          bcnt     [2];
    int          lat      [2];
    logic [15:0] mem      [2][256];

    // Reference model state and predicted outputs
    int          ph [2];
    int          own [2];
    int          lst [2];
    int          start_c [2];
    logic [15:0] e_saddr [2];
    logic [15:0] e_swdata [2];
    logic        e_sen [2];
    logic        e_swe [2];
    logic        e_terr [2];
    logic [1:0]  e_grant [2];
    logic        e_rdy [2][2];
    logic [15:0] e_rd [2][2];

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        ph[k] = 0; own[k] = 0; lst[k] = 1; start_c[k] = 0;
        e_saddr[k] = '0; e_swdata[k] = '0; e_sen[k] = 0; e_swe[k] = 0;
        e_terr[k] = 0; e_grant[k] = 2'b00;
        for (int m = 0; m < 2; m++) begin
            e_rdy[k][m] = 0;
            e_rd[k][m] = '0;
        end
    endtask

    // Predicts the outputs of the next cycle from this cycle's inputs.
    task automatic model_step(input int k);
        int w;
        bit err;
        case (ph[k])
            0: if (m_en[k][0] || m_en[k][1]) begin
                if (m_en[k][0] && m_en[k][1]) w = (k == 0) ? 1 - lst[k] : 0;
                else w = m_en[k][1] ? 1 : 0;
                e_saddr[k] = m_addr[k][w];
                e_swe[k] = m_we[k][w];
                e_swdata[k] = m_wdata[k][w];
                e_sen[k] = 1;
                e_grant[k] = (w == 1) ? 2'b10 : 2'b01;
                own[k] = w;
                start_c[k] = mcyc + 1;
                ph[k] = 1;
            end
            1: if (s_ready[k] || (mcyc - start_c[k] == T - 1)) begin
                err = !s_ready[k];
                e_rd[k][own[k]] = err ? 16'hFFFF : s_rdata[k];
                e_rdy[k][own[k]] = 1;
                e_terr[k] = err;
                e_sen[k] = 0;
                e_swe[k] = 0;
                lst[k] = own[k];
                ph[k] = 2;
                $display("txn inst=%0d master=%0d addr=%h we=%0d data=%h err=%0d",
                         k, own[k], e_saddr[k], m_we[k][own[k]], e_rd[k][own[k]], err);
            end
            default: begin
                e_rdy[k][0] = 0;
                e_rdy[k][1] = 0;
                e_terr[k] = 0;
                e_grant[k] = 2'b00;
                ph[k] = 0;
            end
        endcase
    endtask

    // Compare process: checks every output of both instances each cycle.
    initial begin
        forever begin
            @(negedge clk);
            mcyc++;
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) model_reset(k);
                chk("s_addr", k, 32'(s_addr[k]), 32'(e_saddr[k]));
                chk("s_en", k, 32'(s_en[k]), 32'(e_sen[k]));
                chk("s_we", k, 32'(s_we[k]), 32'(e_swe[k]));
                chk("s_wdata", k, 32'(s_wdata[k]), 32'(e_swdata[k]));
                chk("grant", k, 32'(grant[k]), 32'(e_grant[k]));
                chk("timeout_err", k, 32'(terr[k]), 32'(e_terr[k]));
                for (int m = 0; m < 2; m++) begin
                    chk($sformatf("m%0d_ready", m), k, 32'(m_ready[k][m]), 32'(e_rdy[k][m]));
                    chk($sformatf("m%0d_rdata", m), k, 32'(m_rdata[k][m]), 32'(e_rd[k][m]));
                    if (m_ready[k][m]) chk($sformatf("m%0d_ready_has_req", m), k, 32'(m_en[k][m]), 1);
                    rdy_prev[k][m] = m_ready[k][m];
                end
                if (rst_n) model_step(k);
            end
        end
    end

    task automatic req(input int k, input int m, input logic [15:0] a, input logic w, input logic [15:0] d);
        m_addr[k][m] = a;
        m_we[k][m] = w;
        m_wdata[k][m] = d;
        m_en[k][m] = 1'b1;
    endtask

    // One clock: masters drop en after their ready, memory responds.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                if (!m_en[k][m]) wait_c[k][m] = 0;
                if (m_en[k][m] && rdy_prev[k][m]) begin
                    m_en[k][m] = 1'b0;
                    wait_c[k][m] = 0;
                end else if (m_en[k][m]) begin
                    wait_c[k][m]++;
                    chk("req_wait_bound", k, 32'(wait_c[k][m] < 100), 1);
                end else if (rand_on && $urandom_range(0, 3) == 0) begin
                    req(k, m, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
                end
            end
            if (s_en[k]) begin
                bcnt[k]++;
                if (bcnt[k] == 1 && rand_on)
                    lat[k] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
                s_ready[k] = (bcnt[k] == lat[k]);
                s_rdata[k] = s_ready[k] ? mem[k][s_addr[k][7:0]] : 16'($urandom);
                if (s_ready[k] && s_we[k]) mem[k][s_addr[k][7:0]] = s_wdata[k];
            end else begin
                bcnt[k] = 0;
                s_ready[k] = rand_on && ($urandom_range(0, 7) == 0);
                s_rdata[k] = 16'($urandom);
            end
        end
    endtask

    task automatic wait_rdy(input int m, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!m_ready[0][m] && n < 30);
        for (int k = 0; k < 2; k++) chk("ready_seen", k, 32'(m_ready[k][m]), 1);
    endtask

    task automatic drain();
        int n;
        bit busy;
        n = 0;
        do begin
            step();
            n++;
            busy = 0;
            for (int k = 0; k < 2; k++)
                busy |= m_en[k][0] | m_en[k][1] | s_en[k] | (grant[k] != 2'b00);
        end while (busy && n < 200);
        chk("drained", 0, 32'(busy), 0);
    endtask

    int n;
    int g_cnt [2];
    logic [1:0] g_order [2][4];
    logic [1:0] g_prev [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int m = 0; m < 2; m++) begin
                m_addr[k][m] = '0; m_en[k][m] = 0; m_we[k][m] = 0; m_wdata[k][m] = '0;
                rdy_prev[k][m] = 0; wait_c[k][m] = 0;
            end
            s_rdata[k] = '0; s_ready[k] = 0; bcnt[k] = 0; lat[k] = 1;
            for (int i = 0; i < 256; i++) mem[k][i] = 16'(i * 3);
        end
        #1 rst_n = 1'b0;
        repeat (3) step();
        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", k, 32'(grant[k]), 0);
            chk("rst_s_en", k, 32'(s_en[k]), 0);
            chk("rst_m0_ready", k, 32'(m_ready[k][0]), 0);
            chk("rst_m1_rdata", k, 32'(m_rdata[k][1]), 0);
        end
        step();
        rst_n = 1'b1;
        step();

        // Single read, 2-cycle memory latency
        for (int k = 0; k < 2; k++) begin
            mem[k][8'h10] = 16'hBEEF; lat[k] = 2;
            req(k, 0, 16'h0010, 1'b0, 16'h0000);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1_grant", k, 32'(grant[k]), 32'h1);
            chk("t1_s_addr", k, 32'(s_addr[k]), 32'h0010);
            chk("t1_s_en", k, 32'(s_en[k]), 1);
        end
        wait_rdy(0, n);
        chk("t1_latency", 0, n, 2);
        for (int k = 0; k < 2; k++) begin
            chk("t1_m0_rdata", k, 32'(m_rdata[k][0]), 32'hBEEF);
            chk("t1_m1_ready", k, 32'(m_ready[k][1]), 0);
            chk("t1_m1_rdata", k, 32'(m_rdata[k][1]), 0);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1_ready_pulse", k, 32'(m_ready[k][0]), 0);
            chk("t1_grant_idle", k, 32'(grant[k]), 0);
        end

        // Write pass-through from master 1
        for (int k = 0; k < 2; k++) begin
            lat[k] = 3;
            req(k, 1, 16'h8000, 1'b1, 16'h1234);
        end
        step();
        n = 0;
        while (!m_ready[0][1] && n < 30) begin
            for (int k = 0; k < 2; k++) begin
                chk("t2_s_addr", k, 32'(s_addr[k]), 32'h8000);
                chk("t2_s_we", k, 32'(s_we[k]), 1);
                chk("t2_s_wdata", k, 32'(s_wdata[k]), 32'h1234);
                chk("t2_grant", k, 32'(grant[k]), 32'h2);
            end
            step();
            n++;
        end
        chk("t2_latency", 0, n, 3);
        for (int k = 0; k < 2; k++) begin
            chk("t2_m1_ready", k, 32'(m_ready[k][1]), 1);
            chk("t2_mem_written", k, 32'(mem[k][8'h00]), 32'h1234);
            chk("t2_s_we_clear", k, 32'(s_we[k]), 0);
        end
        step();

        // Watchdog abort, then the pending master 1 request is served
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0; mem[k][8'h40] = 16'h0F0F;
            req(k, 0, 16'h0020, 1'b0, 16'h0000);
        end
        step();
        for (int k = 0; k < 2; k++) req(k, 1, 16'h0040, 1'b0, 16'h0000);
        wait_rdy(0, n);
        chk("t3_abort_cycles", 0, n, T);
        for (int k = 0; k < 2; k++) begin
            chk("t3_timeout_err", k, 32'(terr[k]), 1);
            chk("t3_m0_rdata", k, 32'(m_rdata[k][0]), 32'hFFFF);
            chk("t3_m1_ready", k, 32'(m_ready[k][1]), 0);
            lat[k] = 1;
        end
        step();
        for (int k = 0; k < 2; k++) chk("t3_err_pulse", k, 32'(terr[k]), 0);
        step();
        for (int k = 0; k < 2; k++) chk("t3_m1_granted", k, 32'(grant[k]), 32'h2);
        wait_rdy(1, n);
        for (int k = 0; k < 2; k++) chk("t3_m1_rdata", k, 32'(m_rdata[k][1]), 32'h0F0F);
        step();

        // Acknowledge in the very cycle the watchdog would fire
        for (int k = 0; k < 2; k++) begin
            lat[k] = T; mem[k][8'h30] = 16'h5A5A;
            req(k, 0, 16'h0030, 1'b0, 16'h0000);
        end
        step();
        wait_rdy(0, n);
        chk("t4_latency", 0, n, T);
        for (int k = 0; k < 2; k++) begin
            chk("t4_no_err", k, 32'(terr[k]), 0);
            chk("t4_m0_rdata", k, 32'(m_rdata[k][0]), 32'h5A5A);
        end
        step();

        // Reset in the middle of an access
        for (int k = 0; k < 2; k++) begin
            lat[k] = 0;
            req(k, 0, 16'h0050, 1'b0, 16'h0000);
        end
        step();
        step();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t5_grant", k, 32'(grant[k]), 0);
            chk("t5_s_en", k, 32'(s_en[k]), 0);
            chk("t5_s_addr", k, 32'(s_addr[k]), 0);
            chk("t5_m0_rdata", k, 32'(m_rdata[k][0]), 0);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) m_en[k][0] = 1'b0;
        repeat (6) begin
            step();
            for (int k = 0; k < 2; k++) chk("t5_no_ready", k, 32'(m_ready[k][0]), 0);
        end

        // Continuous contention straight after reset
        for (int k = 0; k < 2; k++) begin
            lat[k] = 1; g_cnt[k] = 0; g_prev[k] = 2'b00;
            for (int i = 0; i < 4; i++) g_order[k][i] = 2'b00;
            req(k, 0, 16'h0100, 1'b0, 16'h0000);
            req(k, 1, 16'h0101, 1'b0, 16'h0000);
        end
        for (int s = 0; s < 80 && (g_cnt[0] < 4 || g_cnt[1] < 4); s++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 2; m++)
                    if (!m_en[k][m]) req(k, m, 16'(16'h0100 + m), 1'b0, 16'h0000);
                if (grant[k] != 2'b00 && g_prev[k] == 2'b00 && g_cnt[k] < 4) begin
                    g_order[k][g_cnt[k]] = grant[k];
                    g_cnt[k]++;
                end
                g_prev[k] = grant[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("t6_grant_count", k, g_cnt[k], 4);
            for (int i = 0; i < 4; i++)
                chk($sformatf("t6_grant_%0d", i), k, 32'(g_order[k][i]),
                    (k == 0 && (i % 2) == 1) ? 32'h2 : 32'h1);
        end
        drain();

        // Randomised traffic from both masters with random memory latency
        rand_on = 1;
        repeat (3000) step();
        rand_on = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
